game_state_controller: RTL and testbench

Parametrised game-flow controller for the Frogger top level. It replaces the inline IDLE/RUNNING logic with a registered FSM that adds:
- a configurable life count
- post-hit invulnerability/respawn
- a timed game-over hold
- a saturating level counter

It sits between Collisions/Character_Control and the LEDs, Obstacles_Movement and Sprite_Display.

---
 rtl/game_state_controller_pkg.sv | 26 ++
 rtl/game_state_controller_if.sv | 27 ++
 rtl/game_state_controller_rising_edge_detect.sv | 28 ++
 rtl/game_state_controller.sv | 142 ++++++++++++++
 tb/tb_game_state_controller.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_state_controller_pkg.sv
// Shared types and defaults for the Frogger game-flow controller.
// The state encoding is visible on o_State, so the enum values are fixed.
package game_state_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUNNING   = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam int DEFAULT_NUM_LIVES            = 3;
    localparam int DEFAULT_INVULN_CYCLES        = 25000000;
    localparam int DEFAULT_GAMEOVER_HOLD_CYCLES = 50000000;
    localparam int DEFAULT_MAX_LEVEL            = 15;
    localparam int DEFAULT_LEVEL_WIDTH          = 4;

    // A start held through reset must not launch a game, so its history resets high.
    localparam bit START_PREV_RESET = 1'b1;
    localparam bit COLL_PREV_RESET  = 1'b0;

    function automatic int timer_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Bundles the game-flow event inputs and status outputs of the controller.
interface game_state_controller_if #(
    parameter int NUM_LIVES   = 3,
    parameter int LEVEL_WIDTH = 4
) ();

    logic                   i_Start;
    logic                   i_Collision;
    logic                   i_Level_Up;
    logic [1:0]             o_State;
    logic                   o_Game_Active;
    logic                   o_Invulnerable;
    logic                   o_Respawn;
    logic [NUM_LIVES-1:0]   o_Lives;
    logic [LEVEL_WIDTH-1:0] o_Level;

    modport master (
        output i_Start, i_Collision, i_Level_Up,
        input  o_State, o_Game_Active, o_Invulnerable, o_Respawn, o_Lives, o_Level
    );

    modport slave (
        input  i_Start, i_Collision, i_Level_Up,
        output o_State, o_Game_Active, o_Invulnerable, o_Respawn, o_Lives, o_Level
    );

endinterface

// File: rtl/game_state_controller_rising_edge_detect.sv
// Rising-edge detector with a configurable history value out of reset.
module game_state_controller_rising_edge_detect #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev_d;
    logic prev_q;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RESET_VALUE;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/game_state_controller.sv
// Frogger game-flow FSM: lives, post-hit invulnerability, timed game-over hold
// and a saturating level counter, with every output registered.
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int NUM_LIVES            = DEFAULT_NUM_LIVES,
    parameter int INVULN_CYCLES        = DEFAULT_INVULN_CYCLES,
    parameter int GAMEOVER_HOLD_CYCLES = DEFAULT_GAMEOVER_HOLD_CYCLES,
    parameter int MAX_LEVEL            = DEFAULT_MAX_LEVEL,
    parameter int LEVEL_WIDTH          = DEFAULT_LEVEL_WIDTH
) (
    input logic                    i_Clk,
    input logic                    i_Reset,
    game_state_controller_if.slave bus
);

    localparam int INVULN_W = timer_width(INVULN_CYCLES);
    localparam int HOLD_W   = timer_width(GAMEOVER_HOLD_CYCLES);

    localparam logic [INVULN_W-1:0]    INVULN_LOAD = INVULN_W'(INVULN_CYCLES - 1);
    localparam logic [HOLD_W-1:0]      HOLD_LOAD   = HOLD_W'(GAMEOVER_HOLD_CYCLES - 1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX   = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [NUM_LIVES-1:0]   LAST_LIFE   = NUM_LIVES'(1);

    logic start_edge;
    logic coll_edge;

    game_state_t            state_d,        state_q;
    logic [NUM_LIVES-1:0]   lives_d,        lives_q;
    logic [LEVEL_WIDTH-1:0] level_d,        level_q;
    logic [INVULN_W-1:0]    invuln_timer_d, invuln_timer_q;
    logic [HOLD_W-1:0]      hold_timer_d,   hold_timer_q;
    logic                   respawn_d,      respawn_q;
    logic                   game_active_d,  game_active_q;
    logic                   invulnerable_d, invulnerable_q;
    logic [LEVEL_WIDTH-1:0] level_inc;

    game_state_controller_rising_edge_detect #(.RESET_VALUE(START_PREV_RESET)) u_start_edge (
        .clk  (i_Clk),
        .rst  (i_Reset),
        .sig  (bus.i_Start),
        .rise (start_edge)
    );

    game_state_controller_rising_edge_detect #(.RESET_VALUE(COLL_PREV_RESET)) u_coll_edge (
        .clk  (i_Clk),
        .rst  (i_Reset),
        .sig  (bus.i_Collision),
        .rise (coll_edge)
    );

    assign level_inc = (level_q < LEVEL_MAX) ? level_q + 1'b1 : level_q;

    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        level_d        = level_q;
        invuln_timer_d = invuln_timer_q;
        hold_timer_d   = hold_timer_q;
        respawn_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    lives_d = '1;
                    level_d = '0;
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                // A collision on the same cycle as a level-up wins and the level is left alone.
                if (coll_edge) begin
                    respawn_d = 1'b1;
                    if (lives_q == LAST_LIFE) begin
                        lives_d      = '0;
                        hold_timer_d = HOLD_LOAD;
                        state_d      = GAME_OVER;
                    end else begin
                        lives_d        = lives_q >> 1;
                        invuln_timer_d = INVULN_LOAD;
                        state_d        = RESPAWN;
                    end
                end else if (bus.i_Level_Up) begin
                    level_d = level_inc;
                end
            end
            RESPAWN: begin
                if (bus.i_Level_Up) begin
                    level_d = level_inc;
                end
                if (invuln_timer_q == '0) begin
                    state_d = RUNNING;
                end else begin
                    invuln_timer_d = invuln_timer_q - 1'b1;
                end
            end
            GAME_OVER: begin
                if (hold_timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_timer_d = hold_timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        game_active_d  = (state_d == RUNNING) || (state_d == RESPAWN);
        invulnerable_d = (state_d == RESPAWN);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q        <= IDLE;
            lives_q        <= '1;
            level_q        <= '0;
            invuln_timer_q <= '0;
            hold_timer_q   <= '0;
            respawn_q      <= 1'b0;
            game_active_q  <= 1'b0;
            invulnerable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            level_q        <= level_d;
            invuln_timer_q <= invuln_timer_d;
            hold_timer_q   <= hold_timer_d;
            respawn_q      <= respawn_d;
            game_active_q  <= game_active_d;
            invulnerable_q <= invulnerable_d;
        end
    end

    assign bus.o_State        = state_q;
    assign bus.o_Game_Active  = game_active_q;
    assign bus.o_Invulnerable = invulnerable_q;
    assign bus.o_Respawn      = respawn_q;
    assign bus.o_Lives        = lives_q;
    assign bus.o_Level        = level_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed game scenarios followed by random play, every cycle compared against
// a life/level/countdown model of the game rules.
module tb_game_state_controller;

    localparam int NUM_LIVES            = 3;
    localparam int INVULN_CYCLES        = 4;
    localparam int GAMEOVER_HOLD_CYCLES = 8;
    localparam int MAX_LEVEL            = 3;
    localparam int LEVEL_WIDTH          = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    game_state_controller_if #(.NUM_LIVES(NUM_LIVES), .LEVEL_WIDTH(LEVEL_WIDTH)) bus ();

    game_state_controller #(
        .NUM_LIVES            (NUM_LIVES),
        .INVULN_CYCLES        (INVULN_CYCLES),
        .GAMEOVER_HOLD_CYCLES (GAMEOVER_HOLD_CYCLES),
        .MAX_LEVEL            (MAX_LEVEL),
        .LEVEL_WIDTH          (LEVEL_WIDTH)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: phase 0 idle, 1 playing, 2 recovering from a hit, 3 game over.
    int m_phase;
    int m_lives_left;
    int m_level;
    int m_cycles_left;
    bit m_hit_pulse;
    bit m_prev_start;
    bit m_prev_coll;

    bit s_cur;
    bit c_cur;
    int respawn_pulses;
    int invuln_cycles;
    int over_cycles;

    task automatic model_step(input bit r, input bit s, input bit c, input bit l);
        bit s_edge;
        bit c_edge;
        if (r) begin
            m_phase       = 0;
            m_lives_left  = NUM_LIVES;
            m_level       = 0;
            m_cycles_left = 0;
            m_hit_pulse   = 1'b0;
            m_prev_start  = 1'b1;
            m_prev_coll   = 1'b0;
            return;
        end
        s_edge       = s && !m_prev_start;
        c_edge       = c && !m_prev_coll;
        m_prev_start = s;
        m_prev_coll  = c;
        m_hit_pulse  = 1'b0;
        case (m_phase)
            0: if (s_edge) begin
                m_lives_left = NUM_LIVES;
                m_level      = 0;
                m_phase      = 1;
            end
            1: if (c_edge) begin
                m_hit_pulse  = 1'b1;
                m_lives_left = m_lives_left - 1;
                if (m_lives_left == 0) begin
                    m_phase       = 3;
                    m_cycles_left = GAMEOVER_HOLD_CYCLES;
                end else begin
                    m_phase       = 2;
                    m_cycles_left = INVULN_CYCLES;
                end
            end else if (l && m_level < MAX_LEVEL) begin
                m_level = m_level + 1;
            end
            2: begin
                if (l && m_level < MAX_LEVEL) m_level = m_level + 1;
                m_cycles_left = m_cycles_left - 1;
                if (m_cycles_left == 0) m_phase = 1;
            end
            default: begin
                m_cycles_left = m_cycles_left - 1;
                if (m_cycles_left == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_output();
        check_value("state",        32'(bus.o_State),        32'(m_phase));
        check_value("game_active",  32'(bus.o_Game_Active),  32'(m_phase == 1 || m_phase == 2));
        check_value("invulnerable", 32'(bus.o_Invulnerable), 32'(m_phase == 2));
        check_value("respawn",      32'(bus.o_Respawn),      32'(m_hit_pulse));
        check_value("lives",        32'(bus.o_Lives),        (32'd1 << m_lives_left) - 32'd1);
        check_value("level",        32'(bus.o_Level),        32'(m_level));
    endtask

    task automatic apply_stimulus(input bit r, input bit s, input bit c, input bit l);
        rst             = r;
        bus.i_Start     = s;
        bus.i_Collision = c;
        bus.i_Level_Up  = l;
        @(posedge clk);
        model_step(r, s, c, l);
        #1;
        check_output();
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_Start     = 1'b1;
        bus.i_Collision = 1'b0;
        bus.i_Level_Up  = 1'b0;

        // Start held through reset must not launch a game.
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0);
        check_value("held_start_idle", 32'(bus.o_State), 32'd0);
        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0);
        check_value("launch_state", 32'(bus.o_State), 32'd1);
        check_value("launch_lives", 32'(bus.o_Lives), 32'b111);
        check_value("launch_level", 32'(bus.o_Level), 32'd0);

        // Long collision flag: one hit, four invulnerable cycles.
        respawn_pulses = 0;
        invuln_cycles  = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, 1, 1, 0);
            respawn_pulses += int'(bus.o_Respawn);
            invuln_cycles  += int'(bus.o_Invulnerable);
        end
        check_value("long_hit_pulses", 32'(respawn_pulses), 32'd1);
        check_value("long_hit_invuln", 32'(invuln_cycles), 32'd4);
        check_value("long_hit_lives", 32'(bus.o_Lives), 32'b011);
        check_value("long_hit_state", 32'(bus.o_State), 32'd1);
        apply_stimulus(0, 1, 0, 0);

        // Two more hits end the game; a start edge inside the hold is ignored.
        apply_stimulus(0, 1, 1, 0);
        check_value("second_hit_lives", 32'(bus.o_Lives), 32'b001);
        for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 1, 1, 0);
        check_value("fatal_hit_lives", 32'(bus.o_Lives), 32'd0);
        check_value("fatal_hit_pulse", 32'(bus.o_Respawn), 32'd1);
        over_cycles = int'(bus.o_State == 2'd3);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, (i != 0), 0, 0);
            over_cycles += int'(bus.o_State == 2'd3);
        end
        check_value("game_over_cycles", 32'(over_cycles), 32'd8);
        check_value("after_hold_state", 32'(bus.o_State), 32'd0);

        // Level counting, saturation, and collision priority over level-up.
        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 1, 1, 1);
        check_value("coincident_level", 32'(bus.o_Level), 32'd0);
        check_value("coincident_lives", 32'(bus.o_Lives), 32'b011);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 1, 0, 1);
        check_value("level_1", 32'(bus.o_Level), 32'd1);
        apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 1, 0, 1);
        check_value("level_2", 32'(bus.o_Level), 32'd2);
        apply_stimulus(0, 1, 1, 0);
        apply_stimulus(0, 1, 0, 1);
        check_value("level_3_respawn", 32'(bus.o_Level), 32'd3);
        apply_stimulus(0, 1, 0, 1);
        check_value("level_sat_respawn", 32'(bus.o_Level), 32'd3);
        check_value("still_invulnerable", 32'(bus.o_Invulnerable), 32'd1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 1, 0, 1);
        check_value("level_sat_running", 32'(bus.o_Level), 32'd3);

        // Reset during recovery on the last life.
        apply_stimulus(0, 1, 1, 0);
        for (int i = 0; i < 9; i++) apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 1);
        apply_stimulus(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 1, 1, 0);
        apply_stimulus(0, 1, 0, 0);
        check_value("pre_reset_lives", 32'(bus.o_Lives), 32'b001);
        apply_stimulus(1, 1, 0, 0);
        check_value("reset_state", 32'(bus.o_State), 32'd0);
        check_value("reset_lives", 32'(bus.o_Lives), 32'b111);
        check_value("reset_level", 32'(bus.o_Level), 32'd0);
        check_value("reset_invuln", 32'(bus.o_Invulnerable), 32'd0);

        // Random play.
        s_cur = 1'b1;
        c_cur = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) s_cur = ~s_cur;
            if ($urandom_range(0, 4) == 0) c_cur = ~c_cur;
            apply_stimulus(($urandom_range(0, 99) == 0), s_cur, c_cur, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
